uart_frame_rx: RTL and testbench

Receive-side frame deframer sitting directly downstream of `uart_top`'s byte output stream (`out_dat_o/out_vld_o/out_rdy_i`). It hunts for a start-of-frame byte, collects a length-prefixed payload into an internal buffer and checks an XOR checksum. Only verified payloads are released on a valid/ready byte stream with a last flag. Corrupt, oversize or stalled frames are dropped and reported with a one-cycle error pulse and code.

---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_buf.sv | 27 ++
 rtl/uart_frame_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the uart_frame_rx deframer.
// Holds the start-of-frame marker, the FSM state encoding and the error codes.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h7E;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DRAIN
    } frame_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_BAD_CHK = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for uart_frame_rx: DEPTH x 8 registers, one synchronous write
// port and one combinational read port. The storage itself is never reset.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_dat,
    input  logic [IW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_dat
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer for the uart_top byte stream: SOF, LEN, payload, XOR checksum.
// Define UART_FRAME_TIMEOUT_EN to build the inter-byte timeout (error code 3).
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] in_dat_i,
    input  logic       in_vld_i,
    output logic       in_rdy_o,
    output logic [7:0] out_dat_o,
    output logic       out_vld_o,
    output logic       out_last_o,
    input  logic       out_rdy_i,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);

    localparam int         LW        = $clog2(MAX_LEN + 1);
    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_badMaxLen
        $error("uart_frame_rx: MAX_LEN must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
        $error("uart_frame_rx: TIMEOUT_CYCLES must be at least 2");
    end

    frame_state_e   r_state;
    frame_state_e   w_stateNext;
    logic           r_alive;
    logic [LW-1:0]  r_len;
    logic [LW-1:0]  r_wrPtr;
    logic [LW-1:0]  r_rdPtr;
    logic [7:0]     r_xor;
    logic           r_frameOk;
    logic           r_frameErr;
    err_code_e      r_errCode;

    logic           w_inXfer;
    logic           w_outXfer;
    logic           w_lenBad;
    logic           w_dataLast;
    logic           w_outLast;
    logic           w_abort;
    logic           w_bufWr;
    logic           w_timeout;
    logic           w_okSet;
    logic           w_errSet;
    err_code_e      w_errCodeNext;
    logic [7:0]     w_rdDat;

    // r_alive keeps in_rdy_o low while reset is held even if en is already high.
    assign in_rdy_o   = r_alive & en & (r_state != ST_DRAIN);
    assign w_inXfer   = in_vld_i & in_rdy_o;
    assign out_vld_o  = (r_state == ST_DRAIN);
    assign w_outXfer  = out_vld_o & out_rdy_i;
    assign w_outLast  = out_vld_o & (r_rdPtr == r_len - LW'(1));
    assign out_last_o = w_outLast;
    assign out_dat_o  = out_vld_o ? w_rdDat : 8'h00;
    assign w_lenBad   = (in_dat_i == 8'h00) || (in_dat_i > MAX_LEN_B);
    assign w_dataLast = (r_wrPtr == r_len - LW'(1));
    assign w_abort    = !en && (r_state inside {ST_LEN, ST_DATA, ST_CHK});
    assign w_bufWr    = (r_state == ST_DATA) & w_inXfer;

    assign frame_ok_o  = r_frameOk;
    assign frame_err_o = r_frameErr;
    assign err_code_o  = r_errCode;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_toCnt;
    logic          w_counting;

    assign w_counting = r_state inside {ST_LEN, ST_DATA, ST_CHK};
    // The count lags elapsed idle cycles by one, so matching TIMEOUT_CYCLES-2
    // raises the pulse exactly TIMEOUT_CYCLES cycles after the last byte.
    assign w_timeout  = en & w_counting & !w_inXfer & (r_toCnt == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toCnt <= '0;
        end else if (w_inXfer || !(w_stateNext inside {ST_LEN, ST_DATA, ST_CHK})) begin
            r_toCnt <= '0;
        end else if (w_counting) begin
            r_toCnt <= r_toCnt + TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_HUNT:  if (w_inXfer && in_dat_i == SOF_BYTE) w_stateNext = ST_LEN;
            ST_LEN:   if (w_inXfer) w_stateNext = w_lenBad ? ST_HUNT : ST_DATA;
            ST_DATA:  if (w_inXfer && w_dataLast) w_stateNext = ST_CHK;
            ST_CHK:   if (w_inXfer) w_stateNext = (in_dat_i == r_xor) ? ST_DRAIN : ST_HUNT;
            ST_DRAIN: if (w_outXfer && w_outLast) w_stateNext = ST_HUNT;
            default:  w_stateNext = ST_HUNT;
        endcase
        if (w_abort || w_timeout) begin
            w_stateNext = ST_HUNT;
        end
    end

    always_comb begin
        w_okSet       = 1'b0;
        w_errSet      = 1'b0;
        w_errCodeNext = ERR_NONE;
        if (r_state == ST_LEN && w_inXfer && w_lenBad) begin
            w_errSet      = 1'b1;
            w_errCodeNext = ERR_BAD_LEN;
        end
        if (r_state == ST_CHK && w_inXfer) begin
            if (in_dat_i == r_xor) begin
                w_okSet = 1'b1;
            end else begin
                w_errSet      = 1'b1;
                w_errCodeNext = ERR_BAD_CHK;
            end
        end
        if (w_timeout) begin
            w_errSet      = 1'b1;
            w_errCodeNext = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_xor      <= 8'h00;
            r_frameOk  <= 1'b0;
            r_frameErr <= 1'b0;
            r_errCode  <= ERR_NONE;
        end else begin
            r_frameOk  <= w_okSet;
            r_frameErr <= w_errSet;
            if (w_errSet) begin
                r_errCode <= w_errCodeNext;
            end

            if (r_state == ST_LEN && w_inXfer && !w_lenBad) begin
                r_len <= in_dat_i[LW-1:0];
                r_xor <= in_dat_i;
            end else if (w_bufWr) begin
                r_xor <= r_xor ^ in_dat_i;
            end

            if (w_stateNext != ST_DATA) begin
                r_wrPtr <= '0;
            end else if (w_bufWr) begin
                r_wrPtr <= r_wrPtr + LW'(1);
            end

            if (w_stateNext != ST_DRAIN) begin
                r_rdPtr <= '0;
            end else if (w_outXfer) begin
                r_rdPtr <= r_rdPtr + LW'(1);
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_bufWr),
        .i_wr_addr (r_wrPtr[IW-1:0]),
        .i_wr_dat  (in_dat_i),
        .i_rd_addr (r_rdPtr[IW-1:0]),
        .o_rd_dat  (w_rdDat)
    );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx with MAX_LEN=4 and TIMEOUT_CYCLES=16.
// Honours UART_FRAME_TIMEOUT_EN the same way the design does.
module tb_uart_frame_rx;

    localparam int MAX_LEN        = 4;
    localparam int TIMEOUT_CYCLES = 16;

    typedef logic [7:0] byteQ_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic [7:0] in_dat_i = 8'h00;
    logic       in_vld_i = 1'b0;
    logic       in_rdy_o;
    logic [7:0] out_dat_o;
    logic       out_vld_o;
    logic       out_last_o;
    logic       out_rdy_i = 1'b1;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;

    int vecCount  = 0;
    int missCount = 0;

    logic [8:0] expOut [$];
    int         expEv  [$];

    logic       prevStall = 1'b0;
    logic [7:0] prevDat;
    logic       prevLast;
    logic [8:0] monExp;
    int         monAct;

    uart_frame_rx #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_dat_i    (in_dat_i),
        .in_vld_i    (in_vld_i),
        .in_rdy_o    (in_rdy_o),
        .out_dat_o   (out_dat_o),
        .out_vld_o   (out_vld_o),
        .out_last_o  (out_last_o),
        .out_rdy_i   (out_rdy_i),
        .frame_ok_o  (frame_ok_o),
        .frame_err_o (frame_err_o),
        .err_code_o  (err_code_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        vecCount++;
        if (act != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: walk a byte list and predict the released payload
    // bytes (with last flag) and the ordered ok/error events it must produce.
    function automatic void modelParse(input byteQ_t q);
        int         i = 0;
        int         len;
        logic [7:0] x;
        while (i < q.size()) begin
            if (q[i] != 8'h7E) begin
                i++;
                continue;
            end
            i++;
            if (i >= q.size()) break;
            len = int'(q[i]);
            i++;
            if (len == 0 || len > MAX_LEN) begin
                expEv.push_back(1);
                continue;
            end
            if (i + len >= q.size()) break;
            x = 8'(len);
            for (int j = 0; j < len; j++) x = x ^ q[i + j];
            if (q[i + len] == x) begin
                expEv.push_back(0);
                for (int j = 0; j < len; j++) expOut.push_back({(j == len - 1), q[i + j]});
            end else begin
                expEv.push_back(2);
            end
            i += len + 1;
        end
    endfunction

    // Offer one byte at the falling edge and hold it until a rising edge accepts it.
    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            in_vld_i = 1'b1;
            in_dat_i = b;
            #1;
            if (in_rdy_o) begin
                @(posedge clk);
                #1;
                in_vld_i = 1'b0;
                done = 1'b1;
            end else if (++waitCycles > 300) begin
                checkOutput("in_rdy wait", 0, 1);
                in_vld_i = 1'b0;
                done = 1'b1;
            end
        end
    endtask

    task automatic sendFrame(input byteQ_t q);
        modelParse(q);
        foreach (q[i]) applyStimulus(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every cycle: score released bytes and ok/err pulses against the model,
    // and require byte and last flag to hold while the consumer stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold vld", int'(out_vld_o), 1);
                checkOutput("hold dat", int'(out_dat_o), int'(prevDat));
                checkOutput("hold last", int'(out_last_o), int'(prevLast));
            end
            if (out_vld_o && out_rdy_i) begin
                if (expOut.size() == 0) begin
                    checkOutput("unexpected byte", int'({out_last_o, out_dat_o}), -1);
                end else begin
                    monExp = expOut.pop_front();
                    checkOutput("out byte", int'(out_dat_o), int'(monExp[7:0]));
                    checkOutput("out last", int'(out_last_o), int'(monExp[8]));
                end
            end
            if (frame_ok_o || frame_err_o) begin
                checkOutput("ok/err exclusive", int'(frame_ok_o & frame_err_o), 0);
                monAct = frame_ok_o ? 0 : int'(err_code_o);
                if (expEv.size() == 0) checkOutput("unexpected event", monAct, -1);
                else checkOutput("frame event", monAct, expEv.pop_front());
            end
            prevStall = out_vld_o & !out_rdy_i;
            prevDat   = out_dat_o;
            prevLast  = out_last_o;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byteQ_t f;
        int     hit;
        int     errSeen;

        // Reset with en already high: everything must read as its reset value.
        #2 rst_n = 1'b0;
        idle(2);
        checkOutput("reset in_rdy", int'(in_rdy_o), 0);
        checkOutput("reset out_vld", int'(out_vld_o), 0);
        checkOutput("reset out_last", int'(out_last_o), 0);
        checkOutput("reset frame_ok", int'(frame_ok_o), 0);
        checkOutput("reset frame_err", int'(frame_err_o), 0);
        checkOutput("reset out_dat", int'(out_dat_o), 0);
        checkOutput("reset err_code", int'(err_code_o), 0);
        rst_n = 1'b1;

        // Good frame, full throughput, exact cycle positions.
        f = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        sendFrame(f);
        @(negedge clk);
        checkOutput("ok pulse", int'(frame_ok_o), 1);
        checkOutput("drain vld", int'(out_vld_o), 1);
        checkOutput("byte0", int'(out_dat_o), 8'h11);
        checkOutput("in_rdy in drain", int'(in_rdy_o), 0);
        @(negedge clk);
        checkOutput("ok one cycle", int'(frame_ok_o), 0);
        checkOutput("byte1", int'(out_dat_o), 8'h22);
        @(negedge clk);
        checkOutput("byte2", int'(out_dat_o), 8'h33);
        checkOutput("byte2 last", int'(out_last_o), 1);
        @(negedge clk);
        checkOutput("in_rdy after drain", int'(in_rdy_o), 1);
        checkOutput("vld after drain", int'(out_vld_o), 0);

        // Bad checksum, then a good frame must still come through.
        f = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        sendFrame(f);
        @(negedge clk);
        checkOutput("chk err pulse", int'(frame_err_o), 1);
        checkOutput("chk err code", int'(err_code_o), 2);
        checkOutput("chk err no vld", int'(out_vld_o), 0);
        @(negedge clk);
        checkOutput("err one cycle", int'(frame_err_o), 0);
        checkOutput("err code held", int'(err_code_o), 2);
        f = '{8'h7E, 8'h01, 8'hA5, 8'hA4};
        sendFrame(f);
        idle(3);

        // Leading junk, zero length, over-length, then maximum length.
        f = '{8'h55, 8'hAA, 8'h7E, 8'h00};
        sendFrame(f);
        @(negedge clk);
        checkOutput("len0 err pulse", int'(frame_err_o), 1);
        checkOutput("len0 err code", int'(err_code_o), 1);
        f = '{8'h7E, 8'h05};
        sendFrame(f);
        @(negedge clk);
        checkOutput("len5 err pulse", int'(frame_err_o), 1);
        checkOutput("len5 err code", int'(err_code_o), 1);
        f = '{8'h7E, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        sendFrame(f);
        idle(6);

        // SOF value inside the payload is plain data.
        f = '{8'h7E, 8'h02, 8'h7E, 8'h11, 8'h6D};
        sendFrame(f);
        @(negedge clk);
        checkOutput("sof as data", int'(out_dat_o), 8'h7E);
        @(negedge clk);
        checkOutput("sof frame byte1", int'(out_dat_o), 8'h11);
        checkOutput("sof frame last", int'(out_last_o), 1);
        idle(2);

        // Consumer stalls mid-drain while the next frame is already waiting.
        f = '{8'h7E, 8'h02, 8'hAB, 8'hCD, 8'h64};
        sendFrame(f);
        out_rdy_i = 1'b0;
        f = '{8'h7E, 8'h01, 8'h5A, 8'h5B};
        modelParse(f);
        fork
            begin
                foreach (f[i]) applyStimulus(f[i]);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall vld", int'(out_vld_o), 1);
                    checkOutput("stall dat", int'(out_dat_o), 8'hAB);
                    checkOutput("stall in_rdy", int'(in_rdy_o), 0);
                end
                @(posedge clk);
                #1 out_rdy_i = 1'b1;
            end
        join
        idle(4);

        // en dropped mid-frame: silent abort, trailing bytes are discarded.
        applyStimulus(8'h7E);
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        en = 1'b0;
        idle(3);
        checkOutput("en low in_rdy", int'(in_rdy_o), 0);
        checkOutput("en low no err", int'(frame_err_o), 0);
        @(posedge clk);
        #1 en = 1'b1;
        f = '{8'h22, 8'h33};
        sendFrame(f);
        f = '{8'h7E, 8'h01, 8'h3C, 8'h3D};
        sendFrame(f);
        idle(3);

        // Stalled frame: timeout when built in, indefinite wait otherwise.
        applyStimulus(8'h7E);
        applyStimulus(8'h02);
        applyStimulus(8'h11);
`ifdef UART_FRAME_TIMEOUT_EN
        expEv.push_back(3);
        hit = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (frame_err_o && hit == 0) begin
                hit = k;
                checkOutput("timeout code", int'(err_code_o), 3);
            end
        end
        checkOutput("timeout cycle", hit, TIMEOUT_CYCLES);
`else
        errSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_err_o) errSeen++;
        end
        checkOutput("no timeout err", errSeen, 0);
        f = '{8'h7E, 8'h02, 8'h11, 8'h22, 8'h31};
        modelParse(f);
        applyStimulus(8'h22);
        applyStimulus(8'h31);
        @(negedge clk);
        checkOutput("resume ok", int'(frame_ok_o), 1);
        idle(3);
`endif

        // Asynchronous reset in the middle of a frame.
        applyStimulus(8'h7E);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset in_rdy", int'(in_rdy_o), 0);
        checkOutput("midreset out_vld", int'(out_vld_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        f = '{8'h7E, 8'h01, 8'hC3, 8'hC2};
        sendFrame(f);
        idle(10);

        checkOutput("pending bytes", expOut.size(), 0);
        checkOutput("pending events", expEv.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
